// File: rtl/ntsc_cursor_ctrl.sv
// Button-driven cursor for the NTSC display: synchronizes and debounces four
// buttons per frame, and steps the cursor with auto-repeat during vertical blanking.
module ntsc_cursor_ctrl #(
    parameter int unsigned DEBOUNCE_FRAMES = 3,
    parameter int unsigned REPEAT_DELAY    = 20,
    parameter int unsigned REPEAT_RATE     = 4,
    parameter logic [5:0]  X_MIN           = 6'd10,
    parameter logic [5:0]  X_MAX           = 6'd56,
    parameter logic [5:0]  Y_MIN           = 6'd0,
    parameter logic [5:0]  Y_MAX           = 6'd30,
    parameter logic [5:0]  X_HOME          = 6'd33,
    parameter logic [5:0]  Y_HOME          = 6'd15
) (
    input  logic       ntscClock,
    input  logic       reset,
    input  logic       left_n,
    input  logic       right_n,
    input  logic       up_n,
    input  logic       down_n,
    input  logic [1:0] vState,
    output logic [5:0] ballX,
    output logic [5:0] ballY,
    output logic       moved
);

    localparam int unsigned DB_W  = $clog2(DEBOUNCE_FRAMES + 1);
    localparam int unsigned R_MAX = (REPEAT_DELAY > REPEAT_RATE) ? REPEAT_DELAY : REPEAT_RATE;
    localparam int unsigned RC_W  = $clog2(R_MAX + 1);

    typedef enum logic [1:0] {IDLE, DELAY, REPEAT} state_t;

    state_t          state;
    logic [3:0]      sync1, sync2, deb, deb_next;
    logic [DB_W-1:0] db_cnt      [4];
    logic [DB_W-1:0] db_cnt_next [4];
    logic [1:0]      vs_q, vs_q2;
    logic            frame_tick;
    logic [RC_W-1:0] rep_cnt, rep_inc;
    logic [3:0]      pair, pair_q;
    logic            step;
    logic [5:0]      nx, ny;

    // Button order in the vectors: 0 left, 1 right, 2 up, 3 down.
    assign frame_tick = (vs_q2 == 2'b00) && (vs_q == 2'b01);

    always_comb begin
        for (int unsigned i = 0; i < 4; i++) begin
            deb_next[i]    = deb[i];
            db_cnt_next[i] = db_cnt[i];
            if (frame_tick) begin
                if (sync2[i] != deb[i]) begin
                    if (db_cnt[i] + DB_W'(1) == DB_W'(DEBOUNCE_FRAMES)) begin
                        deb_next[i]    = sync2[i];
                        db_cnt_next[i] = '0;
                    end else begin
                        db_cnt_next[i] = db_cnt[i] + DB_W'(1);
                    end
                end else begin
                    db_cnt_next[i] = '0;
                end
            end
        end
    end

    // Direction uses the freshly debounced levels so a step lands on the completing tick.
    always_comb begin
        pair[3] = ~deb_next[1] &  deb_next[0];
        pair[2] = ~deb_next[0] &  deb_next[1];
        pair[1] = ~deb_next[3] &  deb_next[2];
        pair[0] = ~deb_next[2] &  deb_next[3];
    end

    assign rep_inc = (rep_cnt == '1) ? rep_cnt : rep_cnt + RC_W'(1);

    always_comb begin
        step = 1'b0;
        if (frame_tick && (pair != '0)) begin
            if (pair != pair_q)
                step = 1'b1;
            else if (state == DELAY && rep_inc == RC_W'(REPEAT_DELAY))
                step = 1'b1;
            else if (state == REPEAT && rep_inc == RC_W'(REPEAT_RATE))
                step = 1'b1;
        end
    end

    always_comb begin
        nx = ballX;
        ny = ballY;
        if (pair[3] && ballX < X_MAX)      nx = ballX + 6'd1;
        else if (pair[2] && ballX > X_MIN) nx = ballX - 6'd1;
        if (pair[1] && ballY < Y_MAX)      ny = ballY + 6'd1;
        else if (pair[0] && ballY > Y_MIN) ny = ballY - 6'd1;
    end

    always_ff @(posedge ntscClock or posedge reset) begin
        if (reset) begin
            sync1   <= '1;
            sync2   <= '1;
            deb     <= '1;
            for (int unsigned i = 0; i < 4; i++) db_cnt[i] <= '0;
            vs_q    <= 2'b00;
            vs_q2   <= 2'b00;
            state   <= IDLE;
            rep_cnt <= '0;
            pair_q  <= '0;
            ballX   <= X_HOME;
            ballY   <= Y_HOME;
            moved   <= 1'b0;
        end else begin
            sync1  <= {down_n, up_n, right_n, left_n};
            sync2  <= sync1;
            deb    <= deb_next;
            for (int unsigned i = 0; i < 4; i++) db_cnt[i] <= db_cnt_next[i];
            vs_q   <= vState;
            vs_q2  <= vs_q;
            moved  <= 1'b0;
            if (frame_tick) begin
                pair_q <= pair;
                if (pair == '0) begin
                    state   <= IDLE;
                    rep_cnt <= '0;
                end else if (pair != pair_q) begin
                    state   <= DELAY;
                    rep_cnt <= '0;
                end else begin
                    case (state)
                        DELAY: begin
                            if (step) begin
                                state   <= REPEAT;
                                rep_cnt <= '0;
                            end else begin
                                rep_cnt <= rep_inc;
                            end
                        end
                        REPEAT:  rep_cnt <= step ? '0 : rep_inc;
                        default: rep_cnt <= rep_inc;
                    endcase
                end
            end
            if (step) begin
                ballX <= nx;
                ballY <= ny;
                moved <= (nx != ballX) || (ny != ballY);
            end
        end
    end

endmodule

// File: doc/ntsc_cursor_ctrl.md
NTSC_CURSOR_CTRL -- requirements
Module: ntsc_cursor_ctrl

Interface
REQ-001 SHALL have parameter DEBOUNCE_FRAMES, default 3: consecutive frame ticks a synchronized button level must hold before its debounced level changes.
REQ-002 SHALL have parameter REPEAT_DELAY, default 20: frame ticks from the initial step to the first auto-repeat step.
REQ-003 SHALL have parameter REPEAT_RATE, default 4: frame ticks between subsequent auto-repeat steps.
REQ-004 SHALL have parameters X_MIN, X_MAX, Y_MIN, Y_MAX, X_HOME, Y_HOME, defaults 10, 56, 0, 30, 33, 15: cursor bounds and home position in 6-bit cells.
REQ-005 SHALL have port ntscClock, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-006 SHALL have port reset, input, 1 bit: asynchronous, active-high reset.
REQ-007 SHALL have ports left_n, right_n, up_n, down_n, input, 1 bit each: asynchronous, active-low buttons.
REQ-008 SHALL have port vState, input, 2 bits: vertical state from the timing generator, encoded 00 visible, 01 presync, 10 sync, 11 postsync.
REQ-009 SHALL have ports ballX and ballY, output, 6 bits each: registered cursor cell coordinates.
REQ-010 SHALL have port moved, output, 1 bit: one-cycle pulse in the cycle ballX or ballY changes.

Function
REQ-011 SHALL pass each button through a 2-flop synchronizer before any other use.
REQ-012 SHALL register vState and generate frameTick for exactly one cycle when the registered value goes from 00 to 01; all other vState transitions SHALL NOT generate frameTick.
REQ-013 SHALL debounce each button with a per-button counter: on each frameTick, count if the synchronized level differs from the debounced level, otherwise clear to 0; when the count reaches DEBOUNCE_FRAMES, update the debounced level and clear the counter.
REQ-014 SHALL form the X direction as +1 when only right is pressed, -1 when only left is pressed, and 0 when neither or both are pressed; Y SHALL be formed likewise from down (+1) and up (-1).
REQ-015 SHALL run the repeat FSM with states IDLE, DELAY and REPEAT, and a frame counter that advances only on frameTick.
REQ-016 SHALL, in any state on a frameTick where the direction pair (X,Y) is nonzero and differs from the pair latched at the previous tick, apply a step, latch the pair, load the counter and go to DELAY.
REQ-017 SHALL, in DELAY, step when the counter reaches REPEAT_DELAY and then go to REPEAT; in REPEAT, step every REPEAT_RATE ticks.
REQ-018 SHALL, on any frameTick with direction pair (0,0), go to IDLE with no step.
REQ-019 SHALL update ballX and ballY in the cycle after the frameTick that produces a step, which is within vertical blanking; the outputs SHALL NOT change at any other time.
REQ-020 SHALL apply both axes in the same step when both are nonzero.
REQ-021 SHALL saturate each axis at its bounds with no wrap-around: a step beyond X_MIN/X_MAX or Y_MIN/Y_MAX holds the coordinate.
REQ-022 SHALL assert moved only if at least one coordinate actually changed; a saturated step SHALL NOT assert moved.
REQ-023 SHALL saturate the frame counter at its width and SHALL NOT let it wrap, whether the FSM holds or not.

Reset
REQ-024 SHALL, while reset is high, asynchronously set ballX=X_HOME, ballY=Y_HOME, moved=0, FSM=IDLE, all counters 0, debounced levels released (1), synchronizers 1, latched direction pair (0,0) and registered vState 00.
REQ-025 SHALL, when reset asserts mid-hold or mid-repeat, discard all progress; after release a still-held button requires a full DEBOUNCE_FRAMES before the first step.
REQ-026 SHALL NOT generate frameTick in the first cycle after reset release, even if vState is already 01.

Verification
REQ-027 Hold right_n=0 from reset release, with frames cycling vState 00->01->10->11 -> ballX goes 33->34 at tick 3 (with moved pulse), ->35 at tick 23, ->36 at tick 27, then +1 every 4 ticks.
REQ-028 Glitch up_n low for 2 frames, then release -> ballY stays 15 and moved never asserts.
REQ-029 Preload ballX=55 via repeated steps and hold right -> ballX reaches 56 and stays there; moved does not pulse on saturated steps.
REQ-030 Hold left and right together -> ballX unchanged; add down -> ballY increments at debounce completion while X holds.
REQ-031 Assert reset during REPEAT with ballX=40 -> ballX=33 and moved=0 immediately, without waiting for a clock edge; with the button still held, the first step after release comes at tick 3.
REQ-032 Drive vState 00->11->00 (skipping 01) -> no frameTick, so no debounce progress and no step.
